// File: rtl/adv7179_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adv7179_pkg                                                |
// | Description : Shared types and constants for the ADV7179 power-up        |
// |               configuration sequencer: top FSM states, I2C phase codes,  |
// |               encoder write addresses and a small sizing helper.         |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package adv7179_pkg;

  // Top-level sequencer states.
  typedef enum logic [2:0] {
    CFG_IDLE   = 3'd0,
    CFG_HWRST  = 3'd1,
    CFG_SETTLE = 3'd2,
    CFG_LOAD   = 3'd3,
    CFG_XFER   = 3'd4,
    CFG_GAP    = 3'd5,
    CFG_DONE   = 3'd6,
    CFG_FAIL   = 3'd7
  } cfg_state_t;

  // Phases of one 3-byte I2C write; each phase is one or more 4-quarter bits.
  typedef enum logic [1:0] {
    PH_START = 2'd0,
    PH_BIT   = 2'd1,
    PH_ACK   = 2'd2,
    PH_STOP  = 2'd3
  } i2c_phase_t;

  // ADV7179 write addresses for ALSB tied low / high.
  localparam logic [7:0] ADV_ADDR_DEFAULT = 8'h54;
  localparam logic [7:0] ADV_ADDR_ALT     = 8'h56;

  // Largest of three values, used to size the shared delay counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adv7179_i2c_wr3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adv7179_i2c_wr3                                            |
// | Description : Single I2C write engine: START, three bytes MSB first with |
// |               an ACK slot after each, STOP. A NACK aborts the write      |
// |               straight after its ACK slot with a STOP.                   |
// | Ports       : clk, rst (sync, active-low), go (1-cycle request),         |
// |               byte0..byte2 (held stable while busy), sda_in (already     |
// |               synchronised), scl_o (1 = released), sda_oe (1 = pull SDA  |
// |               low), nack (result of the last write), fin (1-cycle pulse  |
// |               after STOP completes).                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module adv7179_i2c_wr3
  import adv7179_pkg::*;
#(
  parameter int CLK_DIV = 148
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  input  logic       sda_in,
  output logic       scl_o,
  output logic       sda_oe,
  output logic       nack,
  output logic       fin
);

  localparam int            QW     = $clog2(CLK_DIV) + 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  logic          active,  active_n;
  i2c_phase_t    phase,   phase_n;
  logic [QW-1:0] qtick,   qtick_n;
  logic [1:0]    quarter, quarter_n;
  logic [2:0]    bitn,    bitn_n;
  logic [1:0]    byten,   byten_n;
  logic [7:0]    shreg,   shreg_n;
  logic          nack_n;
  logic          fin_n;

  // Bus levels {scl, sda_oe} for a given phase/quarter. START drops SDA at
  // q1 with SCL high; STOP releases SDA at q2 with SCL high. Data and ACK
  // bits keep SDA constant for all four quarters so it only moves while
  // SCL is low.
  function automatic logic [1:0] bus_level(input logic act, input i2c_phase_t ph,
                                           input logic [1:0] q, input logic b);
    logic [1:0] lv;
    lv = 2'b10;
    if (act) begin
      case (ph)
        PH_START: lv = (q == 2'd0) ? 2'b10 : (q == 2'd3) ? 2'b01 : 2'b11;
        PH_BIT:   lv = {(q == 2'd1) || (q == 2'd2), ~b};
        PH_ACK:   lv = {(q == 2'd1) || (q == 2'd2), 1'b0};
        PH_STOP:  lv = (q == 2'd0) ? 2'b01 : (q == 2'd1) ? 2'b11 : 2'b10;
        default:  lv = 2'b10;
      endcase
    end
    return lv;
  endfunction

  always_comb begin
    active_n  = active;
    phase_n   = phase;
    qtick_n   = qtick;
    quarter_n = quarter;
    bitn_n    = bitn;
    byten_n   = byten;
    shreg_n   = shreg;
    nack_n    = nack;
    fin_n     = 1'b0;
    if (!active) begin
      if (go) begin
        active_n  = 1'b1;
        phase_n   = PH_START;
        qtick_n   = '0;
        quarter_n = 2'd0;
        nack_n    = 1'b0;
      end
    end else if (qtick != Q_LAST) begin
      qtick_n = qtick + QW'(1);
    end else begin
      qtick_n   = '0;
      quarter_n = quarter + 2'd1;
      // The slave's answer is taken at the end of the second SCL-high quarter.
      if (quarter == 2'd2 && phase == PH_ACK) begin
        nack_n = sda_in;
      end
      if (quarter == 2'd3) begin
        case (phase)
          PH_START: begin
            phase_n = PH_BIT;
            bitn_n  = 3'd7;
            byten_n = 2'd0;
            shreg_n = byte0;
          end
          PH_BIT: begin
            if (bitn == 3'd0) begin
              phase_n = PH_ACK;
            end else begin
              bitn_n  = bitn - 3'd1;
              shreg_n = {shreg[6:0], 1'b0};
            end
          end
          PH_ACK: begin
            if (nack || byten == 2'd2) begin
              phase_n = PH_STOP;
            end else begin
              phase_n = PH_BIT;
              bitn_n  = 3'd7;
              byten_n = byten + 2'd1;
              shreg_n = (byten == 2'd0) ? byte1 : byte2;
            end
          end
          default: begin
            active_n = 1'b0;
            fin_n    = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active  <= 1'b0;
      phase   <= PH_START;
      qtick   <= '0;
      quarter <= 2'd0;
      bitn    <= 3'd0;
      byten   <= 2'd0;
      shreg   <= 8'd0;
      nack    <= 1'b0;
      fin     <= 1'b0;
      scl_o   <= 1'b1;
      sda_oe  <= 1'b0;
    end else begin
      active  <= active_n;
      phase   <= phase_n;
      qtick   <= qtick_n;
      quarter <= quarter_n;
      bitn    <= bitn_n;
      byten   <= byten_n;
      shreg   <= shreg_n;
      nack    <= nack_n;
      fin     <= fin_n;
      {scl_o, sda_oe} <= bus_level(active_n, phase_n, quarter_n, shreg_n[7]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/adv7179_cfg_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adv7179_cfg_seq                                            |
// | Description : ADV7179 power-up sequencer. Pulses the encoder reset,      |
// |               waits for it to settle, then writes every entry of an      |
// |               external register table over I2C with NACK retries and a   |
// |               sticky error report.                                       |
// | Ports       : clk_59m, rst (sync, active-low), start, busy, done (pulse),|
// |               err (sticky), err_idx, rom_idx/rom_data (combinational     |
// |               table, {sub_addr,data}), adv_rst_n, scl_o, sda_oe, sda_i.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module adv7179_cfg_seq
  import adv7179_pkg::*;
#(
  parameter int         CLK_DIV   = 148,
  parameter logic [7:0] DEV_ADDR  = ADV_ADDR_DEFAULT,
  parameter int         NUM_REGS  = 16,
  parameter int         RST_LOW   = 600,
  parameter int         RST_WAIT  = 6000,
  parameter int         MAX_RETRY = 3
) (
  input  logic        clk_59m,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_idx,
  output logic [7:0]  rom_idx,
  input  logic [15:0] rom_data,
  output logic        adv_rst_n,
  output logic        scl_o,
  output logic        sda_oe,
  input  logic        sda_i
);

  localparam int            CW         = $clog2(max3(RST_LOW, RST_WAIT, 4 * CLK_DIV) + 1);
  localparam int            RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] LOW_LAST   = CW'(RST_LOW - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(RST_WAIT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(4 * CLK_DIV - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [7:0]    LAST_IDX   = 8'(NUM_REGS - 1);

  cfg_state_t    state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic [7:0]    sub_addr;
  logic [7:0]    data;
  logic          go;
  logic          sda_meta;
  logic          sda_sync;
  logic          nack;
  logic          fin;

  always_ff @(posedge clk_59m) begin
    if (!rst) begin
      state     <= CFG_IDLE;
      cnt       <= '0;
      retry     <= '0;
      sub_addr  <= 8'd0;
      data      <= 8'd0;
      go        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= 8'd0;
      rom_idx   <= 8'd0;
      adv_rst_n <= 1'b0;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
    end else begin
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
      done     <= 1'b0;
      go       <= 1'b0;
      case (state)
        CFG_IDLE: begin
          if (start) begin
            state     <= CFG_HWRST;
            busy      <= 1'b1;
            err       <= 1'b0;
            retry     <= '0;
            rom_idx   <= 8'd0;
            cnt       <= '0;
            adv_rst_n <= 1'b0;
          end
        end
        CFG_HWRST: begin
          if (cnt == LOW_LAST) begin
            cnt       <= '0;
            adv_rst_n <= 1'b1;
            state     <= CFG_SETTLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CFG_SETTLE: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= CFG_LOAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CFG_LOAD: begin
          sub_addr <= rom_data[15:8];
          data     <= rom_data[7:0];
          go       <= 1'b1;
          state    <= CFG_XFER;
        end
        CFG_XFER: begin
          if (fin) begin
            cnt <= '0;
            if (!nack) begin
              retry <= '0;
              state <= CFG_GAP;
            end else if (retry == RETRY_LAST) begin
              state <= CFG_FAIL;
            end else begin
              retry <= retry + RW'(1);
              state <= CFG_GAP;
            end
          end
        end
        CFG_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            // A non-zero retry count means the previous attempt was NACKed,
            // so the same entry goes out again.
            if (retry != '0) begin
              state <= CFG_LOAD;
            end else if (rom_idx == LAST_IDX) begin
              state <= CFG_DONE;
            end else begin
              rom_idx <= rom_idx + 8'd1;
              state   <= CFG_LOAD;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CFG_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= CFG_IDLE;
        end
        default: begin
          err     <= 1'b1;
          err_idx <= rom_idx;
          busy    <= 1'b0;
          state   <= CFG_IDLE;
        end
      endcase
    end
  end

  adv7179_i2c_wr3 #(
    .CLK_DIV (CLK_DIV)
  ) u_wr3 (
    .clk    (clk_59m),
    .rst    (rst),
    .go     (go),
    .byte0  (DEV_ADDR),
    .byte1  (sub_addr),
    .byte2  (data),
    .sda_in (sda_sync),
    .scl_o  (scl_o),
    .sda_oe (sda_oe),
    .nack   (nack),
    .fin    (fin)
  );

endmodule
`default_nettype wire

// File: tb/tb_adv7179_cfg_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_adv7179_cfg_seq                                         |
// | Description : Self-checking bench for adv7179_cfg_seq with a bus-level   |
// |               I2C slave model that decodes writes and can NACK.          |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_adv7179_cfg_seq;

  localparam int CLK_DIV   = 4;
  localparam int NUM_REGS  = 2;
  localparam int RST_LOW   = 8;
  localparam int RST_WAIT  = 16;
  localparam int MAX_RETRY = 3;

  logic        clk_59m = 1'b0;
  logic        rst     = 1'b0;
  logic        start   = 1'b0;
  logic        busy, done, err, adv_rst_n, scl_o, sda_oe;
  logic [7:0]  err_idx, rom_idx;
  logic [15:0] rom_data;
  logic        slave_pull = 1'b0;
  wire         sda_bus = ~(sda_oe | slave_pull);

  always #5 clk_59m = ~clk_59m;

  assign rom_data = (rom_idx == 8'd0) ? 16'h0000 : 16'h0416;

  adv7179_cfg_seq #(
    .CLK_DIV   (CLK_DIV),
    .DEV_ADDR  (8'h54),
    .NUM_REGS  (NUM_REGS),
    .RST_LOW   (RST_LOW),
    .RST_WAIT  (RST_WAIT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk_59m   (clk_59m),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx),
    .rom_idx   (rom_idx),
    .rom_data  (rom_data),
    .adv_rst_n (adv_rst_n),
    .scl_o     (scl_o),
    .sda_oe    (sda_oe),
    .sda_i     (sda_bus)
  );

  // ---------------- bus monitor / slave model (negedge) ----------------
  int         cyc = 0, n_start = 0, n_stop = 0, n_done = 0, n_done_bad = 0;
  int         tx_total = 0, t_start = 0, last_len = 0;
  int         per_good = 0, per_bad = 0, prev_rise = -1;
  int         low_cnt = 0, last_low = 0, n_rstp = 0;
  int         bitcnt = 0, nbytes = 0;
  int         nack_mode = 0, nack_tx = -1;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_arst = 1'b0, in_tx = 1'b0;
  logic       cs, cd, ack;
  logic [7:0] shreg = 8'd0;
  logic [7:0] cur_b [3];
  logic [7:0] tx_nb [64];
  logic [7:0] tx_b0 [64];
  logic [7:0] tx_b1 [64];
  logic [7:0] tx_b2 [64];

  always @(negedge clk_59m) begin
    cyc++;
    cs = scl_o;
    cd = sda_bus;
    if (done) begin
      n_done++;
      if (busy || err) n_done_bad++;
    end
    if (!busy) low_cnt = 0;
    else if (!adv_rst_n) low_cnt++;
    else if (!prev_arst) begin
      last_low = low_cnt;
      n_rstp++;
      low_cnt = 0;
    end
    prev_arst = adv_rst_n;
    if (!busy) prev_rise = -1;
    if (cs && prev_scl) begin
      if (prev_sda && !cd) begin
        n_start++;
        t_start = cyc;
        in_tx = 1'b1;
        bitcnt = 0;
        nbytes = 0;
        slave_pull = 1'b0;
        prev_rise = -1;
        for (int k = 0; k < 3; k++) cur_b[k] = 8'd0;
      end else if (!prev_sda && cd) begin
        n_stop++;
        last_len = cyc - t_start;
        if (in_tx && tx_total < 64) begin
          tx_nb[tx_total] = 8'(nbytes);
          tx_b0[tx_total] = cur_b[0];
          tx_b1[tx_total] = cur_b[1];
          tx_b2[tx_total] = cur_b[2];
          tx_total++;
        end
        in_tx = 1'b0;
      end
    end else if (cs && !prev_scl) begin
      if (busy && prev_rise >= 0) begin
        if (cyc - prev_rise == 4 * CLK_DIV) per_good++;
        else per_bad++;
      end
      if (busy) prev_rise = cyc;
      if (in_tx && bitcnt < 8) begin
        shreg = {shreg[6:0], cd};
        bitcnt++;
      end
    end else if (!cs && prev_scl && in_tx) begin
      if (bitcnt == 8) begin
        if (nbytes < 3) cur_b[nbytes] = shreg;
        ack = 1'b1;
        if (nack_mode == 1 && tx_total == nack_tx && nbytes == 2) ack = 1'b0;
        if (nack_mode == 2 && nbytes == 1) ack = 1'b0;
        slave_pull = ack;
        nbytes++;
        bitcnt = 9;
      end else if (bitcnt == 9) begin
        slave_pull = 1'b0;
        bitcnt = 0;
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_59m);
    #1;
  endtask

  function automatic logic [31:0] txw(input int k);
    return {tx_nb[k], tx_b0[k], tx_b1[k], tx_b2[k]};
  endfunction

  // Start a run and wait for busy to drop; optionally poke start mid-run.
  task automatic run_seq(input bit poke, input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    for (int i = 0; i < 8000 && busy; i++) begin
      start = poke && (i == 10 || i == 300);
      tick();
    end
    start = 1'b0;
    check({tag, "_run_ends"}, busy, 0);
  endtask

  int b_tx, b_st, b_sp, b_dn, b_bad, b_pbad, b_pgood, b_rp;

  task automatic take_base();
    b_tx = tx_total; b_st = n_start; b_sp = n_stop; b_dn = n_done;
    b_bad = n_done_bad; b_pbad = per_bad; b_pgood = per_good; b_rp = n_rstp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    rst = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_idx", err_idx, 0);
    check("rst_rom_idx", rom_idx, 0);
    check("rst_adv_rst_n", adv_rst_n, 0);
    check("rst_scl", scl_o, 1);
    check("rst_sda_oe", sda_oe, 0);
    rst = 1'b1;
    repeat (2) tick();
    check("idle_adv_rst_n", adv_rst_n, 0);

    // ---- T1: clean run with spurious starts while busy ----
    nack_mode = 0;
    take_base();
    run_seq(1'b1, "t1");
    check("t1_tx_count", tx_total - b_tx, 2);
    check("t1_tx0", txw(b_tx), 32'h03540000);
    check("t1_tx1", txw(b_tx + 1), 32'h03540416);
    check("t1_starts", n_start - b_st, 2);
    check("t1_stops", n_stop - b_sp, 2);
    check("t1_done_pulses", n_done - b_dn, 1);
    check("t1_done_with_busy", n_done_bad - b_bad, 0);
    check("t1_err", err, 0);
    check("t1_rst_pulses", n_rstp - b_rp, 1);
    check("t1_rst_low_len", last_low, RST_LOW);
    // SDA falls one quarter into the 116-quarter (464-cycle) write and
    // rises two quarters before its end: 464 - 3*CLK_DIV.
    check("t1_start_to_stop", last_len, 452);
    check("t1_scl_period_bad", per_bad - b_pbad, 0);
    check("t1_scl_period_seen", (per_good - b_pgood) > 0, 1);
    check("t1_adv_rst_n_held", adv_rst_n, 1);

    // ---- T2: NACK on first attempt of entry 1 ----
    nack_mode = 1;
    nack_tx = tx_total + 1;
    take_base();
    run_seq(1'b0, "t2");
    check("t2_tx_count", tx_total - b_tx, 3);
    check("t2_tx0", txw(b_tx), 32'h03540000);
    check("t2_tx1", txw(b_tx + 1), 32'h03540416);
    check("t2_tx2", txw(b_tx + 2), 32'h03540416);
    check("t2_done_pulses", n_done - b_dn, 1);
    check("t2_err", err, 0);
    check("t2_rst_pulses", n_rstp - b_rp, 1);
    check("t2_rst_low_len", last_low, RST_LOW);

    // ---- T3: sub-address always NACKed -> retries exhausted ----
    nack_mode = 2;
    take_base();
    run_seq(1'b0, "t3");
    check("t3_tx_count", tx_total - b_tx, 4);
    for (int k = 0; k < 4; k++) check("t3_attempt", txw(b_tx + k), 32'h02540000);
    check("t3_stops", n_stop - b_sp, 4);
    check("t3_err", err, 1);
    check("t3_err_idx", err_idx, 0);
    check("t3_done_pulses", n_done - b_dn, 0);

    // ---- T4: reset during 2nd bit of the data byte, then rerun ----
    nack_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err_cleared", err, 0);
    check("t4_busy", busy, 1);
    for (int i = 0; i < 4000 && !(nbytes == 2 && bitcnt == 1 && !scl_o); i++) tick();
    check("t4_reached_data", (nbytes == 2 && bitcnt == 1), 1);
    repeat (CLK_DIV) tick();
    check("t4_pre_rst_sda_oe", sda_oe, 1);
    rst = 1'b0;
    tick();
    check("t4_scl", scl_o, 1);
    check("t4_sda_oe", sda_oe, 0);
    check("t4_busy_rst", busy, 0);
    check("t4_adv_rst_n", adv_rst_n, 0);
    rst = 1'b1;
    tick();
    take_base();
    run_seq(1'b0, "t4r");
    check("t4_tx_count", tx_total - b_tx, 2);
    check("t4_tx0", txw(b_tx), 32'h03540000);
    check("t4_tx1", txw(b_tx + 1), 32'h03540416);
    check("t4_done_pulses", n_done - b_dn, 1);
    check("t4_rst_low_len", last_low, RST_LOW);
    check("t4_err", err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
